// File: rtl/reset_release_sequencer.sv
// rtl/reset_release_sequencer.sv - staged reset release after hold, with software re-run
// Optional sticky cause output enabled by RESET_SEQ_CAUSE_LOG_EN.
module reset_release_sequencer #(
  parameter int NUM_STAGES  = 3,
  parameter int HOLD_CYCLES = 16,
  parameter int GAP_CYCLES  = 4,
  parameter int CNT_W       = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  io_sw_req,
  output logic [NUM_STAGES-1:0] io_rst_out,
  output logic                  io_done,
  output logic                  io_busy
`ifdef RESET_SEQ_CAUSE_LOG_EN
  ,
  output logic [1:0]            io_cause
`endif
);

  localparam int IDX_W = $clog2(NUM_STAGES) + 1;

  localparam logic [1:0] ST_HOLD    = 2'd0;
  localparam logic [1:0] ST_RELEASE = 2'd1;
  localparam logic [1:0] ST_RUN     = 2'd2;

  localparam logic [CNT_W-1:0]      HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]      GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0]      STAGE_LAST = IDX_W'(NUM_STAGES - 1);
  localparam logic [NUM_STAGES-1:0] STAGE_ONE  = NUM_STAGES'(1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= ST_HOLD;
      cnt        <= '0;
      idx        <= '0;
      io_rst_out <= '1;
      io_done    <= 1'b0;
      io_busy    <= 1'b1;
    end else if (io_sw_req || state == 2'd3) begin
      // A software request (or an illegal encoding) restarts the full hold.
      state      <= ST_HOLD;
      cnt        <= '0;
      idx        <= '0;
      io_rst_out <= '1;
      io_done    <= 1'b0;
      io_busy    <= 1'b1;
    end else begin
      case (state)
        ST_HOLD: begin
          if (cnt == HOLD_LAST) begin
            state <= ST_RELEASE;
            cnt   <= '0;
            idx   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RELEASE: begin
          if (cnt == GAP_LAST) begin
            cnt        <= '0;
            idx        <= idx + 1'b1;
            io_rst_out <= io_rst_out & ~(STAGE_ONE << idx);
            if (idx == STAGE_LAST) begin
              state   <= ST_RUN;
              io_done <= 1'b1;
              io_busy <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          cnt        <= '0;
          io_rst_out <= '0;
          io_done    <= 1'b1;
          io_busy    <= 1'b0;
        end
      endcase
    end
  end

`ifdef RESET_SEQ_CAUSE_LOG_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      io_cause <= 2'b01;
    else if (io_sw_req)
      io_cause <= 2'b10;
  end
`endif

endmodule
